// File: rtl/float_pack.sv
// Reduced float format shared by the coprocessor arithmetic blocks.
// Field widths come from TB_MANT_SIZE / TB_EXP_SIZE, defaulting to 8 / 4.
`ifndef TB_MANT_SIZE
`define TB_MANT_SIZE 8
`endif
`ifndef TB_EXP_SIZE
`define TB_EXP_SIZE 4
`endif

package float_pack;

  localparam int N_mantisse = `TB_MANT_SIZE;
  localparam int N_exposant = `TB_EXP_SIZE;

  typedef struct packed {
    logic                  signe;
    logic [N_exposant-1:0] exposant;
    logic [N_mantisse-1:0] mantisse;
  } float;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Exponent bias, held at the signed working width of the divider.
  localparam logic [N_exposant+1:0] D_e = (N_exposant+2)'((32'sd1 <<< (N_exposant-1)) - 32'sd1);

  localparam float FLOAT_ZERO = '{signe: 1'b0, exposant: {N_exposant{1'b0}}, mantisse: {N_mantisse{1'b0}}};
  localparam float FLOAT_MAX  = '{signe: 1'b0,
                                  exposant: {{(N_exposant-1){1'b1}}, 1'b0},
                                  mantisse: {N_mantisse{1'b1}}};

  function automatic logic float_is_zero(input float f);
    return (f.exposant == {N_exposant{1'b0}});
  endfunction

endpackage

// File: rtl/float_mant_divider.sv
// Restoring mantissa divider: one quotient bit per cycle, N_mantisse+2 bits total.
// The first bit is resolved on the load edge itself, straight from the inputs.
module float_mant_divider
  import float_pack::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [N_mantisse:0]   dividend,
  input  logic [N_mantisse:0]   divisor,
  output logic [N_mantisse+1:0] quotient,
  output logic                  done
);

  localparam int QW = N_mantisse + 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW);

  logic [QW-1:0]       rem_r;
  logic [QW-1:0]       q_r;
  logic [N_mantisse:0] div_r;
  logic [CW-1:0]       cnt_r;

  logic [QW-1:0] cur_rem_s;
  logic [QW-1:0] cur_div_s;
  logic [QW-1:0] diff_s;
  logic [QW-1:0] step_rem_s;
  logic          step_bit_s;

  // One shift/subtract step, fed from the inputs on load and from the registers otherwise.
  always_comb begin
    if (load) begin
      cur_rem_s = {1'b0, dividend};
      cur_div_s = {1'b0, divisor};
    end else begin
      cur_rem_s = rem_r;
      cur_div_s = {1'b0, div_r};
    end
    step_bit_s = (cur_rem_s >= cur_div_s);
    if (step_bit_s) begin
      diff_s = cur_rem_s - cur_div_s;
    end else begin
      diff_s = cur_rem_s;
    end
    step_rem_s = diff_s << 1;
  end

  // Remainder, quotient and step counter; counter at zero means no division in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r <= {QW{1'b0}};
      q_r   <= {QW{1'b0}};
      div_r <= {(N_mantisse+1){1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      rem_r <= step_rem_s;
      q_r   <= {{(QW-1){1'b0}}, step_bit_s};
      div_r <= divisor;
      cnt_r <= CW'(1);
    end else if ((cnt_r != {CW{1'b0}}) && (cnt_r != CNT_LAST)) begin
      rem_r <= step_rem_s;
      q_r   <= {q_r[QW-2:0], step_bit_s};
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign quotient = q_r;
  assign done     = (cnt_r == CNT_LAST);

endmodule

// File: rtl/float_div_seq.sv
// Sequential float divider with start/busy/valid handshake.
// Define FLOAT_DIV_EARLY_OUT_EN to let zero-operand cases bypass CALC/NORM.
module float_div_seq
  import float_pack::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  float op1,
  input  float op2,
  output logic busy,
  output logic valid,
  output float result
);

  localparam logic [N_exposant+1:0] E_ONE = (N_exposant+2)'(1);
  localparam logic [N_exposant+1:0] E_TOP = {2'b00, FLOAT_MAX.exposant};

  div_state_t state_r;
  div_state_t state_next_s;
  float       op1_r;
  float       op2_r;
  float       result_r;
  float       result_s;
  logic       busy_r;
  logic       valid_r;
  logic       load_s;
  logic       early_s;

  logic [N_mantisse+1:0] quotient_s;
  logic                  div_done_s;

  float_mant_divider u_mant_div (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .dividend ({1'b1, op1.mantisse}),
    .divisor  ({1'b1, op2.mantisse}),
    .quotient (quotient_s),
    .done     (div_done_s)
  );

  function automatic float div_result(input float a, input float b, input logic [N_mantisse+1:0] q);
    float                         r;
    logic                         norm;
    logic signed [N_exposant+1:0] e;
    r    = FLOAT_ZERO;
    norm = ~q[N_mantisse+1];
    e    = $signed({2'b00, a.exposant}) - $signed({2'b00, b.exposant}) + $signed(D_e)
         - $signed({{(N_exposant+1){1'b0}}, norm});
    if (float_is_zero(a)) begin
      r = FLOAT_ZERO;
    end else if (float_is_zero(b)) begin
      r = FLOAT_MAX;
    end else if (e < $signed(E_ONE)) begin
      r = FLOAT_ZERO;
    end else if (e > $signed(E_TOP)) begin
      r = FLOAT_MAX;
    end else begin
      r.exposant = e[N_exposant-1:0];
      r.mantisse = norm ? q[N_mantisse-1:0] : q[N_mantisse:1];
    end
    r.signe = a.signe ^ b.signe;
    return r;
  endfunction

  // Next-state logic; a start in DONE is taken just like one in IDLE.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    early_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
`ifdef FLOAT_DIV_EARLY_OUT_EN
          if (float_is_zero(op1) || float_is_zero(op2)) begin
            state_next_s = DONE;
            early_s      = 1'b1;
          end else begin
            state_next_s = CALC;
            load_s       = 1'b1;
          end
`else
          state_next_s = CALC;
          load_s       = 1'b1;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (div_done_s) begin
          state_next_s = NORM;
        end else begin
          state_next_s = CALC;
        end
      end
      NORM:    state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // Early-out results come straight from the inputs; the rest from the latched operands.
  always_comb begin
    if (early_s) begin
      result_s = div_result(op1, op2, quotient_s);
    end else begin
      result_s = div_result(op1_r, op2_r, quotient_s);
    end
  end

  // State, operand latch and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= FLOAT_ZERO;
      op1_r    <= FLOAT_ZERO;
      op2_r    <= FLOAT_ZERO;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == CALC) || (state_next_s == NORM);
      valid_r <= (state_next_s == DONE);
      if (state_next_s == DONE) begin
        result_r <= result_s;
      end
      if (load_s || early_s) begin
        op1_r <= op1;
        op2_r <= op2;
      end
    end
  end

  assign busy   = busy_r;
  assign valid  = valid_r;
  assign result = result_r;

endmodule
